// File: rtl/rv32m_divider_pkg.sv
// Shared definitions for the RV32M divider: operation encodings, FSM states
// and small operation-decode helpers.
package rv32m_divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Even encodings (DIV, REM) are the signed variants.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 selects the remainder as the architectural result.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/rv32m_divider_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial
// subtract the divisor at XLEN+1 bits, keep the difference if it did not borrow.
module rv32m_divider_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Borrow out of the extra top bit means the trial went negative.
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    trial    = shifted - {1'b0, divisor};
    quo_next = {quo[XLEN-2:0], ~trial[XLEN]};
    if (trial[XLEN] == 1'b0) begin
      rem_next = trial[XLEN-1:0];
    end else begin
      rem_next = shifted[XLEN-1:0];
    end
  end

endmodule

// File: rtl/rv32m_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a
// start/busy/done handshake, special-case bypass and synchronous kill.
module rv32m_divider
  import rv32m_divider_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [1:0]      op_sel_i,
  input  logic [XLEN-1:0] op_A_i,
  input  logic [XLEN-1:0] op_B_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   STEP_INC = CW'(STEPS_PER_CYCLE);
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN);

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v, input logic neg);
    return neg ? negate(v) : v;
  endfunction

  state_e          state;
  logic [1:0]      op_sel;
  logic            is_signed;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic            q_neg;
  logic            r_neg;
  logic [CW-1:0]   counter;

  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            overflow;
  logic [CW-1:0]   counter_next;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  // Operand conditioning and special-case detection for the PREP cycle.
  always_comb begin
    abs_a        = cond_negate(op_a, is_signed & op_a[XLEN-1]);
    abs_b        = cond_negate(op_b, is_signed & op_b[XLEN-1]);
    div_zero     = (op_b == ZERO);
    overflow     = is_signed & (op_a == MOST_NEG) & (op_b == ALL_ONES);
    counter_next = counter + STEP_INC;
  end

  // Chain of restoring steps resolved in a single CALC cycle; during CALC
  // op_b already holds the divisor magnitude.
  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : gen_step
    logic [XLEN-1:0] rem_in;
    logic [XLEN-1:0] quo_in;
    logic [XLEN-1:0] rem_out;
    logic [XLEN-1:0] quo_out;

    if (g == 0) begin : gen_first
      assign rem_in = rem;
      assign quo_in = quo;
    end else begin : gen_next
      assign rem_in = gen_step[g-1].rem_out;
      assign quo_in = gen_step[g-1].quo_out;
    end

    rv32m_divider_div_step #(.XLEN(XLEN)) u_div_step (
      .rem      (rem_in),
      .quo      (quo_in),
      .divisor  (op_b),
      .rem_next (rem_out),
      .quo_next (quo_out)
    );
  end

  assign rem_step = gen_step[STEPS_PER_CYCLE-1].rem_out;
  assign quo_step = gen_step[STEPS_PER_CYCLE-1].quo_out;

  // Control FSM and datapath registers, including the registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      op_sel    <= 2'b00;
      is_signed <= 1'b0;
      op_a      <= ZERO;
      op_b      <= ZERO;
      rem       <= ZERO;
      quo       <= ZERO;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      counter   <= {CW{1'b0}};
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= ZERO;
    end else if (kill_i) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            op_sel    <= op_sel_i;
            is_signed <= op_is_signed(op_sel_i);
            op_a      <= op_A_i;
            op_b      <= op_B_i;
            busy_o    <= 1'b1;
            state     <= ST_PREP;
          end else begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_PREP: begin
          counter <= {CW{1'b0}};
          // Special cases park their final values in quo/rem with no sign
          // fix-up pending, so FIX treats them like any other result.
          if (div_zero) begin
            quo   <= ALL_ONES;
            rem   <= op_a;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            state <= ST_FIX;
          end else if (overflow) begin
            quo   <= MOST_NEG;
            rem   <= ZERO;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            state <= ST_FIX;
          end else begin
            quo   <= abs_a;
            rem   <= ZERO;
            op_b  <= abs_b;
            q_neg <= is_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
            r_neg <= is_signed & op_a[XLEN-1];
            state <= ST_CALC;
          end
        end

        ST_CALC: begin
          rem     <= rem_step;
          quo     <= quo_step;
          counter <= counter_next;
          if (counter_next == LAST_CNT) begin
            state <= ST_FIX;
          end else begin
            state <= ST_CALC;
          end
        end

        ST_FIX: begin
          if (op_is_rem(op_sel)) begin
            result_o <= cond_negate(rem, r_neg);
          end else begin
            result_o <= cond_negate(quo, q_neg);
          end
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= ST_DONE;
        end

        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_divider.sv
// Self-checking bench for rv32m_divider: directed cases, a transaction-level
// reference model checked every cycle, and randomized traffic with kills.
module tb_rv32m_divider;

  localparam int XLEN        = 32;
  localparam int LAT         = 2 + XLEN;
  localparam int SPECIAL_LAT = 2;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        kill   = 1'b0;
  logic [1:0]  op_sel = 2'b00;
  logic [31:0] op_a   = 32'd0;
  logic [31:0] op_b   = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  // Model state, written only by the monitor process.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = 32'd0;
  logic [31:0] m_pend = 32'd0;
  int          m_cnt  = 0;

  always #5 clk = ~clk;

  rv32m_divider #(.XLEN(XLEN), .STEPS_PER_CYCLE(1)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .op_sel_i (op_sel),
    .op_A_i   (op_a),
    .op_B_i   (op_b),
    .kill_i   (kill),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (is_special(op, a, b)) return op[1] ? 32'd0 : MIN_NEG;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    sa = a;
    sb = b;
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level monitor: advance the transaction model on each edge, then
  // compare every output shortly after the edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 1'b0; m_done = 1'b0; m_res = 32'd0; m_cnt = 0;
      end else if (kill) begin
        m_busy = 1'b0; m_done = 1'b0;
      end else if (!m_busy && start) begin
        m_busy = 1'b1;
        m_done = 1'b0;
        m_pend = ref_result(op_sel, op_a, op_b);
        m_cnt  = is_special(op_sel, op_a, op_b) ? SPECIAL_LAT : LAT;
      end else if (m_busy) begin
        m_cnt--;
        m_done = 1'b0;
        if (m_cnt == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_res = m_pend;
        end
      end else begin
        m_done = 1'b0;
      end
      #1;
      check("mon_busy", {31'd0, busy}, {31'd0, m_busy});
      check("mon_done", {31'd0, done}, {31'd0, m_done});
      check("mon_result", result, m_res);
    end
  end

  task automatic pulse_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op_sel = op; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    pulse_start(op, a, b);
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, result, exp_res);
  endtask

  initial begin
    int lat;
    int seen;
    int got;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the reference model with hand-computed values
    check("pin_divu", ref_result(2'b01, 32'd100, 32'd7), 32'd14);
    check("pin_remu", ref_result(2'b11, 32'd100, 32'd7), 32'd2);
    check("pin_div_neg", ref_result(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem_neg", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_rem_negdiv", ref_result(2'b10, 32'd7, 32'hFFFF_FFFE), 32'd1);
    check("pin_div_zero", ref_result(2'b00, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("pin_ovf", ref_result(2'b00, MIN_NEG, 32'hFFFF_FFFF), MIN_NEG);

    // Directed operations
    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    do_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    do_op("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 2);
    do_op("div_ovf", 2'b00, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 2);
    do_op("rem_ovf", 2'b10, MIN_NEG, 32'hFFFF_FFFF, 32'd0, 2);
    do_op("divu_big", 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 34);
    do_op("remu_big", 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    do_op("div_min_1", 2'b00, MIN_NEG, 32'd1, MIN_NEG, 34);

    // Back-to-back: start held high through CALC and the DONE cycle
    @(negedge clk);
    start = 1'b1; op_sel = 2'b01; op_a = 32'd1000; op_b = 32'd10;
    @(negedge clk);
    op_sel = 2'b10; op_a = 32'hFFFF_FF9C; op_b = 32'd7;
    wait_done(lat);
    check("b2b_first_latency", 32'(lat), 32'd34);
    check("b2b_first_result", result, 32'd100);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("b2b_second_latency", 32'(lat), 32'd34);
    check("b2b_second_result", result, 32'hFFFF_FFFE);

    // Kill during CALC
    pulse_start(2'b01, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("kill_no_done", 32'(seen), 32'd0);
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_result_kept", result, 32'hFFFF_FFFE);

    // Asynchronous reset in the middle of CALC
    pulse_start(2'b00, 32'd12345, 32'd67);
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_done", {31'd0, done}, 32'd0);
    check("areset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op("post_reset_divu", 2'b01, 32'd100, 32'd7, 32'd14, 34);

    // Randomized traffic; the monitor checks every cycle
    for (int i = 0; i < 80; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin ra = $urandom; rb = 32'd0; end
        1: begin ra = MIN_NEG; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
        3: begin ra = $urandom; rb = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF; end
        4: begin ra = $urandom; rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      @(negedge clk);
      start = 1'b1; op_sel = rop; op_a = ra; op_b = rb;
      @(negedge clk);
      start = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 35)) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
      end else begin
        got = 0;
        for (int k = 1; k <= 100; k++) begin
          @(posedge clk);
          #1;
          if (done) begin
            got = 1;
            break;
          end
          @(negedge clk);
          start = (k >= 3 && k <= 25 && $urandom_range(0, 3) == 0);
          op_a = $urandom;
        end
        start = 1'b0;
        check("rand_done_seen", 32'(got), 32'd1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
